// File: rtl/iommu_regbus_arbiter.sv
// Round-robin arbiter that shares the IOMMU regmap reg-bus port among
// several requesters, one transaction at a time, with a watchdog that
// aborts a stalled downstream access and returns an error response.
module iommu_regbus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ-1:0]              req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb_i,
  output logic [NUM_REQ-1:0]              rsp_ready_o,
  output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
  output logic                            rsp_error_o,
  output logic                            reg_valid_o,
  output logic                            reg_write_o,
  output logic [ADDR_WIDTH-1:0]           reg_addr_o,
  output logic [DATA_WIDTH-1:0]           reg_wdata_o,
  output logic [DATA_WIDTH/8-1:0]         reg_wstrb_o,
  input  logic                            reg_ready_i,
  input  logic [DATA_WIDTH-1:0]           reg_rdata_i,
  input  logic                            reg_error_i,
  output logic                            busy_o,
  output logic [$clog2(NUM_REQ)-1:0]      grant_o,
  output logic                            timeout_o
);

  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int GRANT_WIDTH = $clog2(NUM_REQ);
  localparam int CNT_WIDTH   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]             state;
  logic [GRANT_WIDTH-1:0] grant;
  logic [GRANT_WIDTH-1:0] last_grant;
  logic [GRANT_WIDTH-1:0] pick;
  logic [GRANT_WIDTH-1:0] cand;
  logic                   found;
  logic                   write_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [STRB_WIDTH-1:0]  wstrb_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   error_q;
  logic                   timeout_q;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic                   abort;

  // Round-robin pick: first valid requester searching upward from last_grant+1.
  always_comb begin
    pick  = last_grant;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GRANT_WIDTH'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req_valid_i[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Watchdog: abort when this ISSUE cycle would bring the count up to the limit.
  always_comb begin
    cnt_next = cnt + CNT_WIDTH'(1);
    abort    = (TIMEOUT_CYCLES != 0) && (cnt_next == CNT_WIDTH'(TIMEOUT_CYCLES));
  end

  // Main FSM: latch a granted request, wait for downstream completion, respond.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GRANT_WIDTH'(NUM_REQ - 1);
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant   <= pick;
            write_q <= req_write_i[pick];
            addr_q  <= req_addr_i[pick*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q <= req_wdata_i[pick*DATA_WIDTH +: DATA_WIDTH];
            wstrb_q <= req_wstrb_i[pick*STRB_WIDTH +: STRB_WIDTH];
            cnt     <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (reg_ready_i) begin
            rdata_q <= reg_rdata_i;
            error_q <= reg_error_i;
            state   <= RESP;
          end else if (abort) begin
            rdata_q   <= '0;
            error_q   <= 1'b1;
            timeout_q <= 1'b1;
            state     <= RESP;
          end else if (TIMEOUT_CYCLES != 0) begin
            cnt <= cnt_next;
          end
        end
        RESP: begin
          last_grant <= grant;
          cnt        <= '0;
          timeout_q  <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion pulse goes only to the granted requester, and only in RESP.
  always_comb begin
    rsp_ready_o = '0;
    if (state == RESP) begin
      rsp_ready_o[grant] = 1'b1;
    end
  end

  assign rsp_rdata_o = (state == RESP) ? rdata_q : '0;
  assign rsp_error_o = (state == RESP) && error_q;
  assign reg_valid_o = (state == ISSUE);
  assign reg_write_o = write_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_wstrb_o = wstrb_q;
  assign busy_o      = (state != IDLE);
  assign grant_o     = grant;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_iommu_regbus_arbiter.sv
// Directed bench for iommu_regbus_arbiter: single read, contention,
// round-robin start, timeout, ready-vs-timeout and reset mid-transaction.
module tb_iommu_regbus_arbiter;

  logic          clk;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_write;
  logic [127:0]  req_addr;
  logic [127:0]  req_wdata;
  logic [15:0]   req_wstrb;
  logic [1:0]    rsp_ready;
  logic [63:0]   rsp_rdata;
  logic          rsp_error;
  logic          reg_valid;
  logic          reg_write;
  logic [63:0]   reg_addr;
  logic [63:0]   reg_wdata;
  logic [7:0]    reg_wstrb;
  logic          reg_ready;
  logic [63:0]   reg_rdata;
  logic          reg_error;
  logic          busy;
  logic [0:0]    grant;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  iommu_regbus_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_ready_o(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
    .reg_valid_o(reg_valid), .reg_write_o(reg_write), .reg_addr_o(reg_addr),
    .reg_wdata_o(reg_wdata), .reg_wstrb_o(reg_wstrb),
    .reg_ready_i(reg_ready), .reg_rdata_i(reg_rdata), .reg_error_i(reg_error),
    .busy_o(busy), .grant_o(grant), .timeout_o(timeout)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic rdy,
                               input logic [63:0] rdata, input logic err);
    req_valid = valid;
    reg_ready = rdy;
    reg_rdata = rdata;
    reg_error = err;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Directed sequence of all scenarios.
  initial begin
    rst       = 1'b0;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    applyStimulus(2'b00, 1'b0, 64'h0, 1'b0);

    $display("[TB] reset state");
    doReset();
    checkOutput("rst_reg_valid", 64'(reg_valid), 64'h0);
    checkOutput("rst_rsp_ready", 64'(rsp_ready), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_grant", 64'(grant), 64'h0);
    checkOutput("rst_timeout", 64'(timeout), 64'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 64'h0);

    $display("[TB] single read");
    req_addr[63:0] = 64'h10;
    req_write      = 2'b00;
    applyStimulus(2'b01, 1'b1, 64'hDEAD_BEEF, 1'b0);
    step();
    checkOutput("rd_reg_valid", 64'(reg_valid), 64'h1);
    checkOutput("rd_reg_addr", reg_addr, 64'h10);
    checkOutput("rd_reg_write", 64'(reg_write), 64'h0);
    checkOutput("rd_grant", 64'(grant), 64'h0);
    checkOutput("rd_rsp_early", 64'(rsp_ready), 64'h0);
    step();
    checkOutput("rd_reg_valid_drop", 64'(reg_valid), 64'h0);
    checkOutput("rd_rsp_ready", 64'(rsp_ready), 64'h1);
    checkOutput("rd_rsp_rdata", rsp_rdata, 64'hDEAD_BEEF);
    checkOutput("rd_rsp_error", 64'(rsp_error), 64'h0);
    applyStimulus(2'b00, 1'b0, 64'h0, 1'b0);
    step();
    checkOutput("rd_idle_busy", 64'(busy), 64'h0);
    checkOutput("rd_idle_rsp", 64'(rsp_ready), 64'h0);
    checkOutput("rd_idle_rdata", rsp_rdata, 64'h0);

    $display("[TB] contention");
    doReset();
    req_write            = 2'b10;
    req_addr[63:0]       = 64'h18;
    req_addr[127:64]     = 64'h20;
    req_wdata[127:64]    = 64'h1234;
    req_wstrb[15:8]      = 8'h0F;
    applyStimulus(2'b11, 1'b1, 64'h55, 1'b0);
    for (int t = 0; t < 4; t++) begin
      step();
      checkOutput("ct_reg_valid", 64'(reg_valid), 64'h1);
      checkOutput("ct_grant", 64'(grant), 64'(t % 2));
      if (t % 2 == 1) begin
        checkOutput("ct_wdata", reg_wdata, 64'h1234);
        checkOutput("ct_wstrb", 64'(reg_wstrb), 64'h0F);
        checkOutput("ct_write", 64'(reg_write), 64'h1);
        checkOutput("ct_addr", reg_addr, 64'h20);
      end else begin
        checkOutput("ct_addr", reg_addr, 64'h18);
      end
      step();
      checkOutput("ct_rsp_ready", 64'(rsp_ready), (t % 2 == 1) ? 64'h2 : 64'h1);
      checkOutput("ct_rsp_rdata", rsp_rdata, 64'h55);
      step();
      checkOutput("ct_idle_busy", 64'(busy), 64'h0);
    end
    applyStimulus(2'b00, 1'b0, 64'h0, 1'b0);

    $display("[TB] round-robin start");
    doReset();
    applyStimulus(2'b10, 1'b1, 64'h66, 1'b0);
    step();
    checkOutput("rr_grant_first", 64'(grant), 64'h1);
    step();
    checkOutput("rr_rsp_first", 64'(rsp_ready), 64'h2);
    applyStimulus(2'b11, 1'b1, 64'h66, 1'b0);
    step();
    step();
    checkOutput("rr_grant_second", 64'(grant), 64'h0);
    step();
    checkOutput("rr_rsp_second", 64'(rsp_ready), 64'h1);
    applyStimulus(2'b00, 1'b0, 64'h0, 1'b0);
    step();

    $display("[TB] timeout");
    applyStimulus(2'b01, 1'b0, 64'hAAAA, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step();
      checkOutput("to_reg_valid", 64'(reg_valid), 64'h1);
      checkOutput("to_no_pulse", 64'(timeout), 64'h0);
    end
    step();
    checkOutput("to_reg_valid_drop", 64'(reg_valid), 64'h0);
    checkOutput("to_rsp_ready", 64'(rsp_ready), 64'h1);
    checkOutput("to_rsp_error", 64'(rsp_error), 64'h1);
    checkOutput("to_rsp_rdata", rsp_rdata, 64'h0);
    checkOutput("to_pulse", 64'(timeout), 64'h1);
    applyStimulus(2'b00, 1'b0, 64'h0, 1'b0);
    step();
    checkOutput("to_pulse_end", 64'(timeout), 64'h0);
    applyStimulus(2'b01, 1'b1, 64'h77, 1'b0);
    step();
    step();
    checkOutput("to_next_rsp", 64'(rsp_ready), 64'h1);
    checkOutput("to_next_rdata", rsp_rdata, 64'h77);
    checkOutput("to_next_error", 64'(rsp_error), 64'h0);
    checkOutput("to_next_pulse", 64'(timeout), 64'h0);
    applyStimulus(2'b00, 1'b0, 64'h0, 1'b0);
    step();

    $display("[TB] ready vs timeout");
    applyStimulus(2'b01, 1'b0, 64'h0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step();
    end
    checkOutput("rvt_still_issue", 64'(reg_valid), 64'h1);
    applyStimulus(2'b01, 1'b1, 64'h99, 1'b1);
    step();
    checkOutput("rvt_rsp_ready", 64'(rsp_ready), 64'h1);
    checkOutput("rvt_timeout", 64'(timeout), 64'h0);
    checkOutput("rvt_error", 64'(rsp_error), 64'h1);
    checkOutput("rvt_rdata", rsp_rdata, 64'h99);
    applyStimulus(2'b00, 1'b0, 64'h0, 1'b0);
    step();

    $display("[TB] reset mid-issue");
    applyStimulus(2'b01, 1'b0, 64'h0, 1'b0);
    step();
    step();
    checkOutput("rmi_waiting", 64'(reg_valid), 64'h1);
    doReset();
    checkOutput("rmi_reg_valid", 64'(reg_valid), 64'h0);
    checkOutput("rmi_rsp_ready", 64'(rsp_ready), 64'h0);
    checkOutput("rmi_busy", 64'(busy), 64'h0);
    checkOutput("rmi_reg_addr", reg_addr, 64'h0);
    checkOutput("rmi_grant", 64'(grant), 64'h0);
    applyStimulus(2'b11, 1'b1, 64'h42, 1'b0);
    step();
    checkOutput("rmi_grant_after", 64'(grant), 64'h0);
    step();
    checkOutput("rmi_rsp_after", 64'(rsp_ready), 64'h1);
    applyStimulus(2'b00, 1'b0, 64'h0, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
